// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, FSM encoding,
// instruction field positions and ALU operation codes.
package mcpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 10;
  localparam int RT_MSB  = 9;
  localparam int RT_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  // R-type opcodes occupy 0..4 and write rd rather than rt
  function automatic logic is_rtype(input logic [3:0] op);
    return op <= OP_SLT;
  endfunction

endpackage

// File: rtl/mcpu_alu.sv
// Combinational ALU: add/sub/and/or/signed-compare with a zero flag
// used for branch resolution.
module mcpu_alu
  import mcpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = DATA_W'($signed(a) < $signed(b));
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/mcpu_core.sv
// Multi-cycle 4-register CPU (FETCH/DECODE/EXEC/MEM/WB/HALT) with
// req/ack instruction and data ports. Define MCPU_RETIRE_TRACE_EN to add a
// one-cycle-per-instruction retirement trace port.
module mcpu_core
  import mcpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              halted
`ifdef MCPU_RETIRE_TRACE_EN
  ,
  output logic              retire_valid,
  output logic [PC_W-1:0]   retire_pc,
  output logic              retire_wr_en,
  output logic [1:0]        retire_wr_addr,
  output logic [DATA_W-1:0] retire_wr_data
`endif
);

  logic [2:0]                   state_q, state_d;
  logic [PC_W-1:0]              pc_q, pc_d;
  logic [15:0]                  instr_q, instr_d;
  logic [DATA_W-1:0]            a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]            wb_data_q, wb_data_d;
  logic [DATA_W-1:0]            dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]            dmem_wdata_q, dmem_wdata_d;
  logic                         dmem_we_q, dmem_we_d;
  logic [3:0][DATA_W-1:0]       rf_q, rf_d;

  logic [3:0]        op;
  logic [1:0]        rs, rt, rd, wb_addr;
  logic [7:0]        imm;
  logic [DATA_W-1:0] simm, alu_b, alu_res;
  logic [PC_W-1:0]   pc_inc, br_tgt;
  logic              alu_zero;
  alu_op_e           alu_op;

  assign op      = instr_q[OP_MSB:OP_LSB];
  assign rs      = instr_q[RS_MSB:RS_LSB];
  assign rt      = instr_q[RT_MSB:RT_LSB];
  assign rd      = instr_q[RD_MSB:RD_LSB];
  assign imm     = instr_q[IMM_MSB:IMM_LSB];
  assign simm    = DATA_W'($signed(imm));
  assign wb_addr = is_rtype(op) ? rd : rt;
  assign pc_inc  = pc_q + PC_W'(1);
  // Branch target is formed at 16 bits so it is independent of DATA_W
  assign br_tgt  = PC_W'(16'(pc_q) + 16'd1 + 16'($signed(imm)));

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = b_q;
    case (op)
      OP_SUB:               alu_op = ALU_SUB;
      OP_AND:               alu_op = ALU_AND;
      OP_OR:                alu_op = ALU_OR;
      OP_SLT:               alu_op = ALU_SLT;
      OP_ADDI, OP_LW, OP_SW: alu_b  = simm;
      OP_BEQ, OP_BNE:       alu_op = ALU_SUB;
      default:              alu_op = ALU_ADD;
    endcase
  end

  mcpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (a_q),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    a_d          = a_q;
    b_d          = b_q;
    wb_data_d    = wb_data_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_we_d    = dmem_we_q;
    rf_d         = rf_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wb_data_d = alu_res;
        state_d   = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW: begin
            state_d      = S_MEM;
            dmem_addr_d  = alu_res;
            dmem_wdata_d = b_q;
            dmem_we_d    = (op == OP_SW);
          end
          OP_BEQ:  pc_d = alu_zero ? br_tgt : pc_inc;
          OP_BNE:  pc_d = alu_zero ? pc_inc : br_tgt;
          OP_J:    pc_d = PC_W'(imm);
          OP_HALT: state_d = S_HALT;
          default: pc_d = pc_inc;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (dmem_we_q) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            wb_data_d = dmem_rdata;
            state_d   = S_WB;
          end
        end
      end
      S_WB: begin
        if (wb_addr != 2'd0) rf_d[wb_addr] = wb_data_q;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      instr_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      wb_data_q    <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      rf_q         <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      wb_data_q    <= wb_data_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      rf_q         <= rf_d;
    end
  end

  // Requests are masked while reset is high so an in-flight access drops at once
  assign imem_req   = (state_q == S_FETCH) && !reset;
  assign dmem_req   = (state_q == S_MEM) && !reset;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign halted     = (state_q == S_HALT);

`ifdef MCPU_RETIRE_TRACE_EN
  logic              retire_valid_q, retire_valid_d;
  logic [PC_W-1:0]   retire_pc_q, retire_pc_d;
  logic              retire_wr_en_q, retire_wr_en_d;
  logic [1:0]        retire_wr_addr_q, retire_wr_addr_d;
  logic [DATA_W-1:0] retire_wr_data_q, retire_wr_data_d;

  always_comb begin
    retire_valid_d   = 1'b0;
    retire_pc_d      = pc_q;
    retire_wr_en_d   = 1'b0;
    retire_wr_addr_d = '0;
    retire_wr_data_d = '0;
    case (state_q)
      S_WB: begin
        retire_valid_d   = 1'b1;
        retire_wr_en_d   = (wb_addr != 2'd0);
        retire_wr_addr_d = wb_addr;
        retire_wr_data_d = wb_data_q;
      end
      S_MEM:  retire_valid_d = dmem_ack && dmem_we_q;
      S_EXEC: retire_valid_d = !(is_rtype(op) || op == OP_ADDI || op == OP_LW || op == OP_SW);
      default: retire_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retire_valid_q   <= 1'b0;
      retire_pc_q      <= '0;
      retire_wr_en_q   <= 1'b0;
      retire_wr_addr_q <= '0;
      retire_wr_data_q <= '0;
    end else begin
      retire_valid_q   <= retire_valid_d;
      retire_pc_q      <= retire_pc_d;
      retire_wr_en_q   <= retire_wr_en_d;
      retire_wr_addr_q <= retire_wr_addr_d;
      retire_wr_data_q <= retire_wr_data_d;
    end
  end

  assign retire_valid   = retire_valid_q;
  assign retire_pc      = retire_pc_q;
  assign retire_wr_en   = retire_wr_en_q;
  assign retire_wr_addr = retire_wr_addr_q;
  assign retire_wr_data = retire_wr_data_q;
`endif

endmodule

// File: tb/tb_mcpu_core.sv
// Bench for mcpu_core (PC_W=4): directed scenarios plus random programs checked
// against an instruction-level model of the ISA.
module tb_mcpu_core;

  localparam int DW  = 16;
  localparam int PCW = 4;

  logic          clock, reset;
  logic          imem_req, imem_ack;
  logic [PCW-1:0] imem_addr, pc;
  logic [15:0]   imem_rdata;
  logic          dmem_req, dmem_we, dmem_ack, halted;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
`ifdef MCPU_RETIRE_TRACE_EN
  logic           retire_valid, retire_wr_en;
  logic [PCW-1:0] retire_pc;
  logic [1:0]     retire_wr_addr;
  logic [DW-1:0]  retire_wr_data;
`endif

  mcpu_core #(.DATA_W(DW), .PC_W(PCW)) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .halted     (halted)
`ifdef MCPU_RETIRE_TRACE_EN
    ,
    .retire_valid   (retire_valid),
    .retire_pc      (retire_pc),
    .retire_wr_en   (retire_wr_en),
    .retire_wr_addr (retire_wr_addr),
    .retire_wr_data (retire_wr_data)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // memories and responder knobs
  logic [15:0] imem [16];
  logic [15:0] dmem [256];
  int i_lat = 1, d_lat = 1, i_cnt = 0, d_cnt = 0;
  bit stray = 0, p_iack = 0, p_dack = 0;

  // ISA-level model state
  logic [15:0] m_r [4];
  logic [3:0]  m_pc;
  bit          m_halted;
  bit          exp_dv, exp_dwe;
  logic [15:0] exp_da, exp_dwd;

  // observation
  int cyc = 0, fetch_n = 0, last_fetch_cyc = 0, ret_cnt = 0;
  logic [3:0] last_fetch_addr;
  int dq_addr[$], dq_hold[$], dq_wd[$];
  logic s_ireq, s_dreq, s_halted, s_dwe;
  logic [3:0] s_iaddr, s_pc;
  logic [15:0] s_daddr, s_dwd;

  task automatic mdl_rst();
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    m_pc = '0; m_halted = 0; exp_dv = 0;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [15:0] v);
    if (idx != 2'd0) m_r[idx] = v;
  endtask

  task automatic mdl_exec(input logic [15:0] ins);
    logic [3:0]  op;
    logic [1:0]  rs, rt, rd;
    logic [15:0] a, b, ea;
    int npc;
    op = ins[15:12]; rs = ins[11:10]; rt = ins[9:8]; rd = ins[7:6];
    a = m_r[rs]; b = m_r[rt];
    ea = a + {{8{ins[7]}}, ins[7:0]};
    npc = int'(m_pc) + 1;
    case (op)
      4'h0: wr(rd, a + b);
      4'h1: wr(rd, a - b);
      4'h2: wr(rd, a & b);
      4'h3: wr(rd, a | b);
      4'h4: wr(rd, ($signed(a) < $signed(b)) ? 16'd1 : 16'd0);
      4'h5: wr(rt, ea);
      4'h6: begin exp_dv = 1; exp_da = ea; exp_dwe = 0; wr(rt, dmem[ea[7:0]]); end
      4'h7: begin exp_dv = 1; exp_da = ea; exp_dwe = 1; exp_dwd = b; dmem[ea[7:0]] = b; end
      4'h8: if (a == b) npc = int'(m_pc) + 1 + int'($signed(ins[7:0]));
      4'h9: if (a != b) npc = int'(m_pc) + 1 + int'($signed(ins[7:0]));
      4'hA: npc = int'(ins[7:0]);
      4'hF: begin m_halted = 1; npc = int'(m_pc); end
      default: ;
    endcase
    m_pc = npc[3:0];
  endtask

  // One clock: respond at the falling edge, return just after the rising edge
  task automatic tick();
    @(negedge clock);
    s_ireq = imem_req; s_dreq = dmem_req; s_halted = halted; s_iaddr = imem_addr;
    s_pc = pc; s_dwe = dmem_we; s_daddr = dmem_addr; s_dwd = dmem_wdata;
    imem_ack = 0; dmem_ack = 0;
    imem_rdata = imem[imem_addr];
    dmem_rdata = dmem[dmem_addr[7:0]];
    if (reset) begin
      mdl_rst(); i_cnt = 0; d_cnt = 0; cyc = -1; p_iack = 0; p_dack = 0;
    end else begin
      if (p_iack) chk("ireq_drop", imem_req, 0);
      if (p_dack) chk("dreq_drop", dmem_req, 0);
      p_iack = 0; p_dack = 0;
      if (imem_req) begin
        if (i_cnt + 1 >= i_lat) begin
          imem_ack = 1; p_iack = 1; i_cnt = 0;
          chk("req_excl", dmem_req, 0);
          chk("if_addr", imem_addr, m_pc);
          chk("no_dpend", exp_dv, 0);
          fetch_n++; last_fetch_cyc = cyc; last_fetch_addr = imem_addr;
          mdl_exec(imem[m_pc]);
        end else i_cnt++;
      end else if (stray) imem_ack = 1;
      if (dmem_req) begin
        if (d_cnt + 1 >= d_lat) begin
          dmem_ack = 1; p_dack = 1;
          chk("dm_exp", exp_dv, 1);
          chk("dm_addr", dmem_addr, exp_da);
          chk("dm_we", dmem_we, exp_dwe);
          if (exp_dwe) chk("dm_wdata", dmem_wdata, exp_dwd);
          dq_addr.push_back(int'(dmem_addr)); dq_hold.push_back(d_cnt + 1);
          dq_wd.push_back(int'(dmem_wdata));
          exp_dv = 0; d_cnt = 0;
        end else d_cnt++;
      end else if (stray) dmem_ack = 1;
    end
`ifdef MCPU_RETIRE_TRACE_EN
    if (retire_valid) ret_cnt++;
`endif
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
    dq_addr.delete(); dq_hold.delete(); dq_wd.delete(); ret_cnt = 0;
  endtask

  task automatic run_fetch(input int n);
    int tgt = fetch_n + n;
    int budget = 100 * n;
    while (fetch_n < tgt) begin
      if (budget == 0) begin chk("fetch_timeout", fetch_n, tgt); break; end
      budget--;
      tick();
      if (s_halted) break;
    end
  endtask

  task automatic run_halt(input int budget);
    int b = budget;
    do begin
      if (b == 0) begin chk("halt_timeout", s_halted, 1); break; end
      b--;
      tick();
    end while (!s_halted);
  endtask

  task automatic nops();
    for (int i = 0; i < 16; i++) imem[i] = 16'hB000;
  endtask

  function automatic logic [15:0] rand_ins();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) op = 4'h7;
    if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h5;
    return {op, 12'($urandom)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; imem_ack = 0; dmem_ack = 0; imem_rdata = '0; dmem_rdata = '0;
    nops();
    for (int i = 0; i < 256; i++) dmem[i] = 16'($urandom);
    tick(); tick();
    chk("rst_ireq", s_ireq, 0);
    chk("rst_dreq", s_dreq, 0);
    chk("rst_pc", s_pc, 0);
    chk("rst_halted", s_halted, 0);
    chk("rst_dwe", s_dwe, 0);
    chk("rst_daddr", s_daddr, 0);
    chk("rst_dwd", s_dwd, 0);
    reset = 0;

    // ADDI/ADDI/ADD: 12 cycles to the 4th fetch, r3 = 2 observed via SW
    imem[0] = 16'h5105; imem[1] = 16'h52FD; imem[2] = 16'h06C0;
    imem[3] = 16'h7320; imem[4] = 16'hF000;
    do_reset();
    run_fetch(4);
    chk("t1_cycles", last_fetch_cyc, 12);
    chk("t1_addr", last_fetch_addr, 3);
    run_halt(50);
    chk("t1_nst", dq_wd.size(), 1);
    if (dq_wd.size() > 0) chk("t1_r3", dq_wd[0], 2);

    // SW then LW at 0x10 with 3-cycle dmem latency
    nops(); d_lat = 3;
    imem[0] = 16'h5105; imem[1] = 16'h7110; imem[2] = 16'h6210;
    imem[3] = 16'h7211; imem[4] = 16'hF000;
    dmem[16] = 16'hDEAD;
    do_reset();
    run_halt(100);
    chk("t2_nacc", dq_addr.size(), 3);
    if (dq_addr.size() == 3) begin
      chk("t2_sw_addr", dq_addr[0], 'h10);
      chk("t2_sw_hold", dq_hold[0], 3);
      chk("t2_lw_addr", dq_addr[1], 'h10);
      chk("t2_lw_hold", dq_hold[1], 3);
      chk("t2_r2", dq_wd[2], 5);
    end
    d_lat = 1;

    // BEQ r0,r0,-1 at 5 loops; BNE r0,r0,-1 falls through
    nops(); imem[5] = 16'h80FF;
    do_reset();
    run_fetch(6);
    chk("t3_nop_cyc", last_fetch_cyc, 15);
    run_fetch(1);
    chk("t3_beq_pc", last_fetch_addr, 5);
    chk("t3_beq_cyc", last_fetch_cyc, 18);
    imem[5] = 16'h90FF;
    do_reset();
    run_fetch(7);
    chk("t3_bne_pc", last_fetch_addr, 6);

    // J 0xFF truncates to 0xF, then wraps to 0
    nops(); imem[0] = 16'hA0FF; imem[15] = 16'h5501;
    do_reset();
    run_fetch(2);
    chk("t4_j_pc", last_fetch_addr, 4'hF);
    chk("t4_j_cyc", last_fetch_cyc, 3);
    run_fetch(1);
    chk("t4_wrap_pc", last_fetch_addr, 0);
    chk("t4_addi_cyc", last_fetch_cyc, 7);

    // reset during a stalled fetch
    nops();
    do_reset();
    run_fetch(3);
    i_lat = 1000;
    repeat (5) tick();
    chk("t5_stall_req", s_ireq, 1);
    chk("t5_stall_addr", s_iaddr, 3);
    reset = 1; tick(); reset = 0;
    chk("t5_rst_req", s_ireq, 0);
    tick();
    chk("t5_req_up", s_ireq, 1);
    chk("t5_addr0", s_iaddr, 0);
    chk("t5_pc0", s_pc, 0);
    i_lat = 1;
    run_fetch(1);
    chk("t5_refetch", last_fetch_addr, 0);

    // HALT ignores stray acks
    nops(); imem[0] = 16'h5101; imem[1] = 16'hF000;
    do_reset();
    run_halt(50);
    chk("t6_pc", s_pc, 1);
    stray = 1;
    repeat (4) begin
      tick();
      chk("t6_ireq", s_ireq, 0);
    end
    stray = 0;
    chk("t6_halted", s_halted, 1);
    chk("t6_dreq", s_dreq, 0);
    chk("t6_pc_frozen", s_pc, 1);
`ifdef MCPU_RETIRE_TRACE_EN
    chk("t6_retires", ret_cnt, 2);
`endif

    // random programs against the ISA model
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 16; i++) imem[i] = rand_ins();
      i_lat = $urandom_range(1, 3);
      d_lat = $urandom_range(1, 3);
      stray = 1'($urandom_range(0, 1));
      do_reset();
      run_fetch(40);
      if (s_halted) begin
        chk("rnd_halt", m_halted, 1);
        chk("rnd_halt_pc", s_pc, m_pc);
      end
    end
    stray = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
